buffer_ram_reader: RTL and testbench
====================================

# buffer_ram_reader

Read-side controller for the dual-port frame buffer (`buffer_ram_dp`). On a start pulse it scans one complete frame out of the buffer's read port in raster order and delivers each pixel on a valid/ready stream, with frame and line markers. It sits between the frame buffer and the downstream display or processing logic, opposite the write side that fills the buffer.

## Interface
Parameters:
- `AW`, default 17: RAM address width.
- `DW`, default 16: pixel/data width.
- `IMG_W`, default 160: pixels per line.
- `IMG_H`, default 120: lines per frame. `IMG_W*IMG_H` must be ≤ 2^AW.
- `RD_LAT`, default 1: RAM read latency in cycles; must be ≥ 1.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a frame. Sampled only in IDLE.
- `abort`, input, 1: synchronous frame cancel.
- `addr_out`, output, AW: RAM read address.
- `regread`, output, 1: RAM read strobe, one cycle per pixel.
- `rd_data`, input, DW: RAM read data, valid `RD_LAT` cycles after `regread` is sampled.
- `pix_data`, output, DW: pixel value.
- `pix_valid`, output, 1: pixel available.
- `pix_ready`, input, 1: downstream accepts the pixel.
- `sof`, output, 1: first pixel of the frame. Qualified by `pix_valid`.
- `eol`, output, 1: last pixel of a line. Qualified by `pix_valid`.
- `eof`, output, 1: last pixel of the frame. Qualified by `pix_valid`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the last pixel is accepted.

## Operation
- State machine states: IDLE, REQ, WAIT, OUT, DONE.
- **IDLE:**
  - `start`=1 → REQ.
  - The pixel index, the x counter and the y counter are set to 0.
- **REQ (1 cycle):**
  - `regread`=1.
  - `addr_out` = current linear index.
  - Then → WAIT.
- **WAIT (`RD_LAT` cycles):**
  - `regread`=0.
  - On the last WAIT cycle, `rd_data` is registered into `pix_data`.
  - Then → OUT.
- **OUT:**
  - `pix_valid`=1.
  - `pix_data`, `sof`, `eol` and `eof` are held stable until `pix_valid && pix_ready`.
  - On that handshake:
    - If the pixel is the last of the frame → DONE.
    - Otherwise, increment the index and x, then → REQ.
    - When x = `IMG_W-1`: x wraps to 0 and y increments.
- **DONE (1 cycle):**
  - `done`=1.
  - Then → IDLE.
- Marker definitions:
  - `sof` = (x==0 && y==0).
  - `eol` = (x==`IMG_W-1`).
  - `eof` = (x==`IMG_W-1` && y==`IMG_H-1`).
  - All three are low whenever `pix_valid`=0.
- Address arithmetic:
  - The linear index counts from 0 to `IMG_W*IMG_H-1`, zero-extended to AW bits.
  - No address ≥ `IMG_W*IMG_H` is ever issued. The index does not wrap within a frame.
- `addr_out` holds its last value outside REQ. It is not a don't-care.
- `start` is ignored outside IDLE, including in DONE.
- `abort` in REQ, WAIT or OUT:
  - Next state is IDLE. `pix_valid` drops on the next edge and no `done` pulse is produced.
  - A RAM read already in flight is discarded.
  - `abort` has priority over a simultaneous handshake.
  - `abort` in IDLE or DONE has no effect.

## Timing
- Reset value of every output is 0: `addr_out`, `regread`, `pix_data`, `pix_valid`, `sof`, `eol`, `eof`, `busy`, `done`. The state resets to IDLE.
- Reset asserted mid-frame forces the reset values immediately, without waiting for a clock edge. After deassertion the block waits for a new `start`.
- With `RD_LAT`=1:
  - `start` sampled at edge 0.
  - `regread` is high in cycle 1.
  - `pix_valid` rises in cycle 3.
- Minimum pixel period is `RD_LAT+2` cycles, i.e. 3 cycles by default.
- When `pix_ready` is held high:
  - The next `regread` follows the handshake edge by 1 cycle.
  - `done` is high in the cycle after the handshake of the final pixel.
  - `busy` falls one cycle after `done`.
- At most one read is outstanding at any time.
- During stalls (`pix_valid`=1, `pix_ready`=0), `regread` stays 0 and `addr_out` is unchanged.

## Test plan
Common setup for all scenarios: `IMG_W`=4, `IMG_H`=3, `RD_LAT`=1, and a RAM model returning `rd_data`=addr+16'h100 one cycle after `regread`.

1. **Full frame, `pix_ready`=1:** pulse `start`.
   - Response: 12 pixels 16'h100…16'h10B, one every 3 cycles.
   - Markers: `sof` on pixel 0 only; `eol` on pixels 3, 7, 11; `eof` on pixel 11.
   - Completion: `done` is a single pulse the cycle after pixel 11; `regread` is seen exactly 12 times.
2. **Backpressure:** drop `pix_ready` for 5 cycles while pixel 5 is valid.
   - Response: `pix_data`=16'h105 and `pix_valid`=1 are held for all 5 cycles, with no `regread` and `addr_out`=5.
   - After the stall: the frame completes normally.
3. **Start while busy:** pulse `start` during pixel 2 and again in the DONE cycle.
   - Response: both pulses are ignored; exactly 12 pixels and one `done`.
4. **Abort:** assert `abort` during WAIT of pixel 6.
   - Response: pixel 6 is never presented, `busy`=0 on the next cycle and `done` stays 0.
   - Restart: a new `start` restarts at addr 0 with `sof`=1.
5. **Asynchronous reset mid-OUT:** assert `rst` between clock edges.
   - Response: all outputs are 0 immediately.
   - Restart: after release, a `start` restarts the frame from addr 0.
6. **Abort simultaneous with final handshake:** assert `abort` together with the handshake of pixel 11.
   - Response: the next state is IDLE and no `done` pulse is produced.

Source files
------------

// File: rtl/buffer_ram_reader.sv
// rtl/buffer_ram_reader.sv - raster-order frame scan from buffer RAM onto a valid/ready pixel stream
module buffer_ram_reader #(
  parameter int AW     = 17,
  parameter int DW     = 16,
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] addr_out,
  output logic          regread,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic          busy,
  output logic          done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [WW-1:0] W_LAST = WW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_OUT, S_DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] idx;
  logic [WW-1:0] wcnt;
  logic          at_eol;
  logic          at_eof;
  logic          handshake;

  assign at_eol    = (x == X_LAST);
  assign at_eof    = at_eol && (y == Y_LAST);
  // abort wins over an accepted pixel, so a cancelled frame never advances
  assign handshake = (state == S_OUT) && pix_ready && !abort;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // next-state logic: one read per pixel, abort returns to IDLE from any active state
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_REQ;
      S_REQ:  next_state = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort)               next_state = S_IDLE;
        else if (wcnt == W_LAST) next_state = S_OUT;
      end
      S_OUT: begin
        if (abort)          next_state = S_IDLE;
        else if (pix_ready) next_state = at_eof ? S_DONE : S_REQ;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // datapath: raster counters, read address (held outside REQ), latency counter, pixel capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      idx      <= '0;
      wcnt     <= '0;
      addr_out <= '0;
      pix_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          x    <= '0;
          y    <= '0;
          idx  <= '0;
          wcnt <= '0;
          if (start) addr_out <= '0;
        end
        S_REQ: wcnt <= '0;
        S_WAIT: begin
          wcnt <= wcnt + 1'b1;
          // an aborted read is dropped rather than captured
          if (!abort && wcnt == W_LAST) pix_data <= rd_data;
        end
        S_OUT: begin
          if (handshake && !at_eof) begin
            idx      <= idx + 1'b1;
            addr_out <= idx + 1'b1;
            if (at_eol) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // state-decoded outputs; markers are gated by pix_valid
  always_comb begin
    regread   = (state == S_REQ);
    pix_valid = (state == S_OUT);
    sof       = pix_valid && (x == '0) && (y == '0);
    eol       = pix_valid && at_eol;
    eof       = pix_valid && at_eof;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

endmodule

// File: tb/tb_buffer_ram_reader.sv
// tb/tb_buffer_ram_reader.sv - self-checking bench for buffer_ram_reader
module tb_buffer_ram_reader;

  localparam int AW   = 17;
  localparam int DW   = 16;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] addr_out;
  logic          regread;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          busy;
  logic          done;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int stall_pix;
    int stall_len;
    int abort_pix;
    bit rnd;
    bit start_busy;
    bit abort_final;
    int exp_pix;
    int exp_done;
  } vec_t;

  vec_t vecs[8];

  buffer_ram_reader #(
    .AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .addr_out(addr_out), .regread(regread), .rd_data(rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data = address + 0x100, one cycle after the strobe
  always @(posedge clk) begin
    if (regread) rd_data <= addr_out[DW-1:0] + 16'h100;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic run_frame(input vec_t v);
    int cur = 0;
    int npix = 0;
    int nread = 0;
    int ndone = 0;
    int stall_left = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit seen = 0;
    bit exp_done = 0;
    bit prev_done = 0;
    bit prev_abort = 0;
    bit armed = 0;
    bit hold = 0;
    bit finished = 0;
    bit timed;
    timed = !v.rnd && (v.stall_pix < 0);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    pix_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      chk("done_timing", done, exp_done);
      if (done) ndone++;
      if (prev_done) chk("busy_after_done", busy, 0);
      if (prev_abort) begin
        chk("abort_busy", busy, 0);
        chk("abort_valid", pix_valid, 0);
      end
      if (hold && !prev_abort) chk("stall_hold_valid", pix_valid, 1);
      exp_done = 0;
      prev_done = done;
      prev_abort = 0;
      hold = 0;
      start = 1'b0;
      abort = 1'b0;
      if (regread) begin
        nread++;
        chk("rd_addr", addr_out, cur);
        chk("rd_while_valid", pix_valid, 0);
        if (timed && nread == 1) chk("first_rd_cycle", cyc, 1);
        if (v.abort_pix == cur) armed = 1;
      end else if (armed) begin
        armed = 0;
        chk("abort_wait_valid", pix_valid, 0);
        abort = 1'b1;
        prev_abort = 1;
      end
      if (pix_valid) begin
        if (!seen) begin
          seen = 1;
          npix++;
          if (timed) chk("pix_period", cyc - last_cyc, 3);
          last_cyc = cyc;
          if (cur == v.stall_pix) stall_left = v.stall_len;
          if (v.start_busy && cur == 2) start = 1'b1;
        end
        chk("pix_data", pix_data, 16'h100 + cur);
        chk("pix_addr", addr_out, cur);
        chk("sof", sof, cur == 0);
        chk("eol", eol, (cur % W) == W - 1);
        chk("eof", eof, cur == NPIX - 1);
        if (stall_left > 0) begin
          pix_ready = 1'b0;
          stall_left--;
        end else begin
          pix_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!pix_ready) hold = 1;
        else if (v.abort_final && cur == NPIX - 1) begin
          abort = 1'b1;
          prev_abort = 1;
        end else begin
          if (cur == NPIX - 1) exp_done = 1;
          cur++;
          seen = 0;
        end
      end else begin
        pix_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done && v.start_busy) start = 1'b1;
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    if (!finished) chk("frame_timeout", 0, 1);
    start = 1'b0;
    abort = 1'b0;
    pix_ready = 1'b1;
    chk("pixels_presented", npix, v.exp_pix);
    chk("read_count", nread, (v.abort_pix >= 0) ? v.abort_pix + 1 : NPIX);
    chk("done_count", ndone, v.exp_done);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pix_ready = 1'b1;

    vecs[0] = '{-1, 0, -1, 1'b0, 1'b0, 1'b0, 12, 1};
    vecs[1] = '{ 5, 5, -1, 1'b0, 1'b0, 1'b0, 12, 1};
    vecs[2] = '{-1, 0, -1, 1'b0, 1'b1, 1'b0, 12, 1};
    vecs[3] = '{-1, 0,  6, 1'b0, 1'b0, 1'b0,  6, 0};
    vecs[4] = '{-1, 0, -1, 1'b0, 1'b0, 1'b0, 12, 1};
    vecs[5] = '{-1, 0, -1, 1'b0, 1'b0, 1'b1, 12, 0};
    vecs[6] = '{-1, 0, -1, 1'b1, 1'b0, 1'b0, 12, 1};
    vecs[7] = '{ 2, 3, -1, 1'b1, 1'b0, 1'b0, 12, 1};

    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {addr_out, regread, pix_data, pix_valid, sof, eol, eof, busy, done}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {addr_out, regread, pix_data, pix_valid, sof, eol, eof, busy, done}, 0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // asynchronous reset between edges while a pixel is presented
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pix_valid) break;
      @(negedge clk);
    end
    chk("rst_setup_valid", pix_valid, 1);
    #1 rst = 1'b1;
    #1 chk("async_reset_outputs", {addr_out, regread, pix_data, pix_valid, sof, eol, eof, busy, done}, 0);
    @(negedge clk);
    chk("reset_held_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", busy, 0);
    run_frame(vecs[0]);
    run_frame(vecs[6]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
